// File: rtl/regfile_dump_reader_pkg.sv
// Shared types and record geometry for the register-file dump reader.
package regfile_dump_reader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_DRAIN = 3'd1,
        ST_LOAD  = 3'd2,
        ST_SEND  = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam int RECORD_BYTES = 5;
    localparam int IDX_PAD      = 3;
    localparam int REC_W        = RECORD_BYTES * 8;

endpackage

// File: rtl/regfile_dump_reader_rec_serializer.sv
// Record serializer: load a 40-bit record, emit it MSB byte first; valid the cycle after load.
// Holds byte and valid while m_ready_i is low; flags the final byte and its transfer.
module rec_serializer
    import regfile_dump_reader_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [REC_W-1:0] rec_i,
    output logic             m_valid_o,
    input  logic             m_ready_i,
    output logic [7:0]       m_data_o,
    output logic             final_o,
    output logic             last_xfer_o
);

    logic [REC_W-1:0] shift_q, shift_d;
    logic [2:0]       cnt_q, cnt_d;
    logic             vld_q, vld_d;
    logic             xfer;

    assign xfer        = vld_q && m_ready_i;
    assign m_valid_o   = vld_q;
    assign m_data_o    = shift_q[REC_W-1 -: 8];
    assign final_o     = vld_q && (cnt_q == 3'(RECORD_BYTES - 1));
    assign last_xfer_o = xfer && final_o;

    always_comb begin
        shift_d = shift_q;
        cnt_d   = cnt_q;
        vld_d   = vld_q;
        if (load_i) begin
            shift_d = rec_i;
            cnt_d   = 3'd0;
            vld_d   = 1'b1;
        end else if (xfer) begin
            // Shifting on the final byte too leaves m_data at zero between records.
            shift_d = shift_q << 8;
            if (cnt_q == 3'(RECORD_BYTES - 1)) begin
                vld_d = 1'b0;
            end else begin
                cnt_d = cnt_q + 3'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shift_q <= '0;
            cnt_q   <= 3'd0;
            vld_q   <= 1'b0;
        end else begin
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            vld_q   <= vld_d;
        end
    end

endmodule

// File: rtl/regfile_dump_reader.sv
// Stalls the CPU, reads registers first..last (wrapping) and streams 5-byte records.
// First byte DRAIN_CYCLES+1 cycles after start is sampled; m_ready low holds SEND with the CPU stalled.
module regfile_dump_reader
    import regfile_dump_reader_pkg::*;
#(
    parameter int DATA_W       = 32,
    parameter int ADDR_W       = 5,
    parameter int DRAIN_CYCLES = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] first_idx,
    input  logic [ADDR_W-1:0] last_idx,
    output logic [ADDR_W-1:0] rf_addr,
    input  logic [DATA_W-1:0] rf_data,
    output logic              cpu_stall,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [7:0]        m_data,
    output logic              m_last,
    output logic              busy,
    output logic              done
);

    localparam int DCW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] cur_q, cur_d;
    logic [ADDR_W-1:0] end_q, end_d;
    logic [DCW-1:0]    drain_q, drain_d;
    logic              ser_load;
    logic              ser_final;
    logic              ser_last_xfer;
    logic [REC_W-1:0]  record;

    assign record = {{IDX_PAD{1'b0}}, cur_q, rf_data};
    assign m_last = ser_final && (cur_q == end_q);

    rec_serializer u_ser (
        .clk         (clk),
        .rst         (rst),
        .load_i      (ser_load),
        .rec_i       (record),
        .m_valid_o   (m_valid),
        .m_ready_i   (m_ready),
        .m_data_o    (m_data),
        .final_o     (ser_final),
        .last_xfer_o (ser_last_xfer)
    );

    always_comb begin
        state_d   = state_q;
        cur_d     = cur_q;
        end_d     = end_q;
        drain_d   = drain_q;
        ser_load  = 1'b0;
        rf_addr   = '0;
        busy      = 1'b0;
        cpu_stall = 1'b0;
        done      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    cur_d   = first_idx;
                    end_d   = last_idx;
                    drain_d = '0;
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                busy      = 1'b1;
                cpu_stall = 1'b1;
                if (drain_q == DCW'(DRAIN_CYCLES - 1)) begin
                    state_d = ST_LOAD;
                end else begin
                    drain_d = drain_q + 1'b1;
                end
            end
            ST_LOAD: begin
                busy      = 1'b1;
                cpu_stall = 1'b1;
                rf_addr   = cur_q;
                ser_load  = 1'b1;
                state_d   = ST_SEND;
            end
            ST_SEND: begin
                busy      = 1'b1;
                cpu_stall = 1'b1;
                if (ser_last_xfer) begin
                    if (cur_q == end_q) begin
                        state_d = ST_DONE;
                    end else begin
                        // Index wraps naturally at the register count.
                        cur_d   = cur_q + 1'b1;
                        state_d = ST_LOAD;
                    end
                end
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cur_q   <= '0;
            end_q   <= '0;
            drain_q <= '0;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            end_q   <= end_d;
            drain_q <= drain_d;
        end
    end

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Scoreboard bench for regfile_dump_reader: directed dumps, byte stream checked by a negedge monitor.
module tb_regfile_dump_reader;

    localparam int D = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [4:0]  first_idx = 5'd0;
    logic [4:0]  last_idx = 5'd0;
    logic [4:0]  rf_addr;
    logic [31:0] rf_data;
    logic        cpu_stall, m_valid, m_ready, m_last, busy, done;
    logic [7:0]  m_data;

    int mode = 0;
    assign rf_data = (mode == 1) ? 32'hDEAD_BEEF : (32'h1000_0000 + {27'd0, rf_addr});

    regfile_dump_reader #(.DATA_W(32), .ADDR_W(5), .DRAIN_CYCLES(D)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .first_idx (first_idx),
        .last_idx  (last_idx),
        .rf_addr   (rf_addr),
        .rf_data   (rf_data),
        .cpu_stall (cpu_stall),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .m_last    (m_last),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    logic [8:0] exp_q[$];
    int checks = 0;
    int errors = 0;
    int xfers = 0;
    int done_cnt = 0;

    bit rdy_pat_en = 1'b0;
    bit rdy_val = 1'b1;
    bit pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    int pi = 0;

    initial begin
        m_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (rdy_pat_en) begin
                m_ready = pat[pi];
                pi = (pi + 1) % 4;
            end else begin
                m_ready = rdy_val;
            end
        end
    end

    // Monitor: pops expected {last,byte} on each handshake, checks hold-while-stalled.
    logic       pv = 1'b0;
    logic       pr = 1'b0;
    logic [7:0] pd = 8'd0;
    logic       pl = 1'b0;
    initial begin
        logic [8:0] e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (pv && !pr) begin
                    checks++;
                    if (!(m_valid && m_data == pd && m_last == pl)) begin
                        errors++;
                        $display("FAIL hold_stable: got v=%0b data=%02h last=%0b, need v=1 data=%02h last=%0b",
                                 m_valid, m_data, m_last, pd, pl);
                    end
                end
                if (m_valid) begin
                    checks++;
                    if (!cpu_stall) begin
                        errors++;
                        $display("FAIL stall_in_send: cpu_stall=%0b while m_valid, need 1", cpu_stall);
                    end
                end
                if (m_valid && m_ready) begin
                    xfers++;
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_byte: got data=%02h last=%0b, none expected", m_data, m_last);
                    end else begin
                        e = exp_q.pop_front();
                        if ({m_last, m_data} !== e) begin
                            errors++;
                            $display("FAIL byte: got data=%02h last=%0b, need data=%02h last=%0b",
                                     m_data, m_last, e[7:0], e[8]);
                        end
                    end
                end
                if (done) done_cnt++;
            end
            pv = m_valid && !rst;
            pr = m_ready;
            pd = m_data;
            pl = m_last;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, need %0h", name, act, exp);
        end
    endtask

    task automatic push_rec(input logic [7:0] idx, input logic [31:0] d, input logic last);
        exp_q.push_back({1'b0, idx});
        exp_q.push_back({1'b0, d[31:24]});
        exp_q.push_back({1'b0, d[23:16]});
        exp_q.push_back({1'b0, d[15:8]});
        exp_q.push_back({last, d[7:0]});
    endtask

    task automatic start_dump(input logic [4:0] f, input logic [4:0] l);
        @(posedge clk);
        #2;
        first_idx = f;
        last_idx  = l;
        start     = 1'b1;
        @(posedge clk);
        #2;
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int d0, input int budget);
        int n;
        n = 0;
        while (done_cnt == d0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        if (done_cnt == d0) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: no done after %0d cycles, need done", name, budget);
        end
        repeat (3) @(posedge clk);
        #2;
        chk({name, "_done_once"}, done_cnt - d0, 1);
        chk({name, "_queue_left"}, exp_q.size(), 0);
        chk({name, "_stall_after"}, int'(cpu_stall), 0);
        chk({name, "_busy_after"}, int'(busy), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, need finish");
        $fatal(1);
    end

    initial begin
        int d0, x0, k, n;

        // Reset state
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_rf_addr", int'(rf_addr), 0);
        chk("rst_cpu_stall", int'(cpu_stall), 0);
        chk("rst_m_valid", int'(m_valid), 0);
        chk("rst_m_data", int'(m_data), 0);
        chk("rst_m_last", int'(m_last), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        rst = 1'b0;

        // 1: full dump 0..31
        mode = 0;
        for (int r = 0; r < 32; r++) push_rec(8'(r), 32'h1000_0000 + r, r == 31);
        d0 = done_cnt;
        x0 = xfers;
        start_dump(5'd0, 5'd31);
        chk("t1_busy", int'(busy), 1);
        wait_done("t1", d0, 2000);
        chk("t1_bytes", xfers - x0, 160);

        // 2: single record, first-valid latency
        mode = 1;
        push_rec(8'h03, 32'hDEAD_BEEF, 1'b1);
        d0 = done_cnt;
        x0 = xfers;
        @(posedge clk);
        #2;
        first_idx = 5'd3;
        last_idx  = 5'd3;
        start     = 1'b1;
        @(posedge clk);
        #2;
        start = 1'b0;
        k = 1;
        @(negedge clk);
        while (!m_valid && k < 20) begin
            @(posedge clk);
            k++;
            @(negedge clk);
        end
        chk("t2_first_valid_latency", k, D + 2);
        wait_done("t2", d0, 200);
        chk("t2_bytes", xfers - x0, 5);

        // 3: wrap 30..1
        mode = 0;
        push_rec(8'h1E, 32'h1000_001E, 1'b0);
        push_rec(8'h1F, 32'h1000_001F, 1'b0);
        push_rec(8'h00, 32'h1000_0000, 1'b0);
        push_rec(8'h01, 32'h1000_0001, 1'b1);
        d0 = done_cnt;
        x0 = xfers;
        start_dump(5'd30, 5'd1);
        wait_done("t3", d0, 500);
        chk("t3_bytes", xfers - x0, 20);

        // 4+5: ready pattern 1,0,0,1 with an ignored mid-dump start and index change
        push_rec(8'h08, 32'h1000_0008, 1'b0);
        push_rec(8'h09, 32'h1000_0009, 1'b0);
        push_rec(8'h0A, 32'h1000_000A, 1'b1);
        d0 = done_cnt;
        x0 = xfers;
        rdy_pat_en = 1'b1;
        start_dump(5'd8, 5'd10);
        repeat (12) @(posedge clk);
        #2;
        first_idx = 5'd0;
        last_idx  = 5'd31;
        start     = 1'b1;
        chk("t4_stall_mid", int'(cpu_stall), 1);
        @(posedge clk);
        #2;
        start = 1'b0;
        wait_done("t4", d0, 1000);
        rdy_pat_en = 1'b0;
        chk("t4_bytes", xfers - x0, 15);

        // 6: reset during byte 2 of record 5, then a clean dump
        for (int r = 0; r < 32; r++) push_rec(8'(r), 32'h1000_0000 + r, r == 31);
        x0 = xfers;
        start_dump(5'd0, 5'd31);
        n = 0;
        while (xfers - x0 < 26 && n < 500) begin
            @(posedge clk);
            #2;
            n++;
        end
        chk("t6_reached_rec5", int'(xfers - x0 >= 26), 1);
        rst = 1'b1;
        @(posedge clk);
        #2;
        chk("t6_rst_m_valid", int'(m_valid), 0);
        chk("t6_rst_cpu_stall", int'(cpu_stall), 0);
        chk("t6_rst_busy", int'(busy), 0);
        rst = 1'b0;
        exp_q.delete();
        push_rec(8'h00, 32'h1000_0000, 1'b0);
        push_rec(8'h01, 32'h1000_0001, 1'b0);
        push_rec(8'h02, 32'h1000_0002, 1'b1);
        d0 = done_cnt;
        x0 = xfers;
        start_dump(5'd0, 5'd2);
        wait_done("t6", d0, 500);
        chk("t6_bytes", xfers - x0, 15);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
